// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer: register map, CTRL field layout
// and small helpers used by the per-channel logic.
package sound_pkg;

    // Register offsets within a channel's 4-register window
    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_LENGTH = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_VOL_LSB     = 0;
    localparam int CTRL_WIDTH_LSB   = 5;
    localparam int CTRL_ENV_UP      = 8;
    localparam int CTRL_ENV_PER_LSB = 9;
    localparam int CTRL_LEN_EN      = 12;
    localparam int CTRL_TRIGGER     = 15;

    localparam logic [4:0] VOL_MAX = 5'd31;

    // Stored CTRL fields; packed so that it maps 1:1 onto CTRL[12:0]
    typedef struct packed {
        logic       len_en;    // [12]
        logic [2:0] env_per;   // [11:9]
        logic       env_up;    // [8]
        logic [2:0] width;     // [7:5]
        logic [4:0] init_vol;  // [4:0]
    } ctrl_t;

    // Extract the storable CTRL fields from a write word
    function automatic ctrl_t unpack_ctrl(input logic [15:0] w);
        return ctrl_t'(w[12:0]);
    endfunction

    // One envelope step, saturating at 0 and VOL_MAX
    function automatic logic [4:0] vol_step(input logic [4:0] v, input logic up);
        logic [4:0] r;
        if (up) begin
            if (v == VOL_MAX) r = v;
            else              r = v + 5'd1;
        end else begin
            if (v == 5'd0)    r = v;
            else              r = v - 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sound_seq_chan.sv
// One sound channel's register set, length counter and volume envelope.
// All channel-facing outputs come straight from flops.
module sound_seq_chan
    import sound_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_period,
    input  logic        wr_ctrl,
    input  logic        wr_length,
    input  logic [15:0] wdata,
    input  logic        tick,
    output logic [15:0] period,
    output logic [4:0]  volume,
    output logic [2:0]  width,
    output logic        active,
    output logic [15:0] ctrl_rd,
    output logic [15:0] len_rd,
    output logic [15:0] status
);

    logic [15:0] period_r,  period_s;
    ctrl_t       ctrl_r,    ctrl_s;
    logic [7:0]  len_cnt_r, len_cnt_s;
    logic [2:0]  env_cnt_r, env_cnt_s;
    logic [4:0]  cur_vol_r, cur_vol_s;
    logic        active_r,  active_s;
    logic [4:0]  volume_r,  volume_s;

    ctrl_t       wr_fields_s;
    logic        trig_s;
    logic        len_step_s;
    logic        env_step_s;

    // Next state: writes and triggers win; tick updates fill in the rest
    always_comb begin
        wr_fields_s = unpack_ctrl(wdata);
        trig_s      = wr_ctrl & wdata[CTRL_TRIGGER];
        // A trigger reloads counters, so the tick is not applied on top of it
        len_step_s  = tick & active_r & ctrl_r.len_en & (len_cnt_r != 8'd0)
                      & ~trig_s & ~wr_length;
        env_step_s  = tick & active_r & (ctrl_r.env_per != 3'd0) & ~trig_s;

        period_s  = period_r;
        ctrl_s    = ctrl_r;
        len_cnt_s = len_cnt_r;
        env_cnt_s = env_cnt_r;
        cur_vol_s = cur_vol_r;
        active_s  = active_r;
        volume_s  = 5'd0;

        if (wr_period) period_s = wdata;
        else           period_s = period_r;

        if (wr_ctrl) ctrl_s = wr_fields_s;
        else         ctrl_s = ctrl_r;

        if (wr_length) begin
            len_cnt_s = wdata[7:0];
        end else if (len_step_s) begin
            len_cnt_s = len_cnt_r - 8'd1;
            if (len_cnt_r == 8'd1) active_s = 1'b0;
            else                   active_s = active_r;
        end else begin
            len_cnt_s = len_cnt_r;
        end

        if (trig_s) begin
            cur_vol_s = wr_fields_s.init_vol;
            env_cnt_s = wr_fields_s.env_per;
            // A trigger with an exhausted length counter does not start the channel
            active_s  = ~(wr_fields_s.len_en & (len_cnt_r == 8'd0));
        end else if (env_step_s) begin
            if (env_cnt_r <= 3'd1) begin
                cur_vol_s = vol_step(cur_vol_r, ctrl_r.env_up);
                env_cnt_s = ctrl_r.env_per;
            end else begin
                cur_vol_s = cur_vol_r;
                env_cnt_s = env_cnt_r - 3'd1;
            end
        end else begin
            cur_vol_s = cur_vol_r;
            env_cnt_s = env_cnt_r;
        end

        if (active_s) volume_s = cur_vol_s;
        else          volume_s = 5'd0;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r  <= 16'd0;
            ctrl_r    <= '0;
            len_cnt_r <= 8'd0;
            env_cnt_r <= 3'd0;
            cur_vol_r <= 5'd0;
            active_r  <= 1'b0;
            volume_r  <= 5'd0;
        end else begin
            period_r  <= period_s;
            ctrl_r    <= ctrl_s;
            len_cnt_r <= len_cnt_s;
            env_cnt_r <= env_cnt_s;
            cur_vol_r <= cur_vol_s;
            active_r  <= active_s;
            volume_r  <= volume_s;
        end
    end

    assign period  = period_r;
    assign volume  = volume_r;
    assign width   = ctrl_r.width;
    assign active  = active_r;
    assign ctrl_rd = {3'd0, ctrl_r};
    assign len_rd  = {8'd0, len_cnt_r};
    assign status  = {7'd0, active_r, env_cnt_r, cur_vol_r};

endmodule

// File: rtl/sound_sequencer.sv
// CPU-facing register file and frame timebase for a bank of sound channels.
// Holds the frame divider, address decode and registered read mux; per-channel
// state lives in sound_seq_chan.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int FRAME_DIV = 100000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DIV_W     = $clog2(FRAME_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CH_W+1:0]       addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic [16*NUM_CH-1:0]  ch_period,
    output logic [5*NUM_CH-1:0]   ch_volume,
    output logic [3*NUM_CH-1:0]   ch_width,
    output logic [NUM_CH-1:0]     ch_active,
    output logic                  frame_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_r, div_s;
    logic             tick_s;
    logic             frame_tick_r, frame_tick_s;

    logic [1:0]       reg_sel_s;
    logic [CH_W-1:0]  ch_idx_s;
    logic             ch_ok_s;

    logic [NUM_CH-1:0][15:0] rd_ch_s;
    logic [15:0]             rd_mux_s;
    logic [15:0]             rdata_r;

    assign reg_sel_s = addr[1:0];
    assign ch_idx_s  = addr[CH_W+1:2];
    assign ch_ok_s   = (32'(ch_idx_s) < NUM_CH);

    // Frame divider: wraps at FRAME_DIV-1; the tick is the wrap cycle
    always_comb begin
        tick_s = (div_r == DIV_LAST);
        if (tick_s) div_s = '0;
        else        div_s = div_r + DIV_ONE;
        frame_tick_s = (div_s == DIV_LAST);
    end

    // Divider and frame_tick registers; frame_tick mirrors the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r        <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            div_r        <= div_s;
            frame_tick_r <= frame_tick_s;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic        hit_s;
        logic [15:0] ctrl_rd_s;
        logic [15:0] len_rd_s;
        logic [15:0] status_s;
        logic [15:0] rd_val_s;

        assign hit_s = wr_en & ch_ok_s & (ch_idx_s == CH_W'(i));

        sound_seq_chan u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_period (hit_s & (reg_sel_s == REG_PERIOD)),
            .wr_ctrl   (hit_s & (reg_sel_s == REG_CTRL)),
            .wr_length (hit_s & (reg_sel_s == REG_LENGTH)),
            .wdata     (wdata),
            .tick      (tick_s),
            .period    (ch_period[16*i +: 16]),
            .volume    (ch_volume[5*i +: 5]),
            .width     (ch_width[3*i +: 3]),
            .active    (ch_active[i]),
            .ctrl_rd   (ctrl_rd_s),
            .len_rd    (len_rd_s),
            .status    (status_s)
        );

        // Per-channel register select for the read path
        always_comb begin
            case (reg_sel_s)
                REG_PERIOD: rd_val_s = ch_period[16*i +: 16];
                REG_CTRL:   rd_val_s = ctrl_rd_s;
                REG_LENGTH: rd_val_s = len_rd_s;
                REG_STATUS: rd_val_s = status_s;
                default:    rd_val_s = 16'd0;
            endcase
        end

        assign rd_ch_s[i] = rd_val_s;
    end

    // Channel select for the read path; an out-of-range channel reads 0
    always_comb begin
        rd_mux_s = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = rd_mux_s |
                       (((ch_ok_s) && (ch_idx_s == CH_W'(i))) ? rd_ch_s[i] : 16'd0);
        end
    end

    // Read data register: captures pre-write state on rd_en, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 16'd0;
        end else if (rd_en) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata      = rdata_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sound_sequencer.sv
// Randomised scoreboard bench for sound_sequencer (NUM_CH=4, FRAME_DIV=8).
module tb_sound_sequencer;

    localparam int NCH = 4;
    localparam int FD  = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  addr  = 4'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic [63:0] ch_period;
    logic [19:0] ch_volume;
    logic [11:0] ch_width;
    logic [3:0]  ch_active;
    logic        frame_tick;

    always #5 clk = ~clk;

    sound_sequencer #(.NUM_CH(NCH), .FRAME_DIV(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ch_period  (ch_period),
        .ch_volume  (ch_volume),
        .ch_width   (ch_width),
        .ch_active  (ch_active),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [63:0] period;
        logic [19:0] volume;
        logic [11:0] width;
        logic [3:0]  active;
        logic        ft;
        logic        rd_chk;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state
    int m_period[NCH], m_init[NCH], m_width[NCH], m_up[NCH], m_per[NCH];
    int m_len_en[NCH], m_len[NCH], m_envc[NCH], m_vol[NCH], m_act[NCH];
    int m_k;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c] = 0; m_init[c] = 0; m_width[c] = 0; m_up[c] = 0; m_per[c] = 0;
            m_len_en[c] = 0; m_len[c] = 0; m_envc[c] = 0; m_vol[c] = 0; m_act[c] = 0;
        end
        m_k = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge and queue the expected outputs
    task automatic model_step(input logic we, input logic re, input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        int   ch, r;
        bit   tick, trig, act_old, mine;
        ch = int'(a[3:2]);
        r  = int'(a[1:0]);

        e.rd_chk = re && (r != 2);
        e.rdata  = 16'd0;
        if (re) begin
            if (r == 0)      e.rdata = 16'(m_period[ch]);
            else if (r == 1) e.rdata = 16'(m_init[ch] + 32*m_width[ch] + 256*m_up[ch]
                                           + 512*m_per[ch] + 4096*m_len_en[ch]);
            else if (r == 3) e.rdata = 16'(m_vol[ch] + 32*m_envc[ch] + 256*m_act[ch]);
        end

        tick = ((m_k % FD) == FD - 1);
        trig = we && (r == 1) && d[15];
        for (int c = 0; c < NCH; c++) begin
            mine    = we && (c == ch);
            act_old = (m_act[c] != 0);
            if (tick && act_old && m_len_en[c] != 0 && m_len[c] > 0 && !(mine && (r == 2 || trig))) begin
                m_len[c] = m_len[c] - 1;
                if (m_len[c] == 0) m_act[c] = 0;
            end
            if (tick && act_old && m_per[c] != 0 && !(mine && trig)) begin
                if (m_envc[c] <= 1) begin
                    if (m_up[c] != 0) m_vol[c] = (m_vol[c] < 31) ? m_vol[c] + 1 : 31;
                    else              m_vol[c] = (m_vol[c] > 0)  ? m_vol[c] - 1 : 0;
                    m_envc[c] = m_per[c];
                end else begin
                    m_envc[c] = m_envc[c] - 1;
                end
            end
        end

        if (we) begin
            case (r)
                0: m_period[ch] = int'(d);
                1: begin
                    m_init[ch]   = int'(d[4:0]);
                    m_width[ch]  = int'(d[7:5]);
                    m_up[ch]     = int'(d[8]);
                    m_per[ch]    = int'(d[11:9]);
                    m_len_en[ch] = int'(d[12]);
                    if (d[15]) begin
                        m_vol[ch]  = m_init[ch];
                        m_envc[ch] = m_per[ch];
                        m_act[ch]  = (m_len_en[ch] != 0 && m_len[ch] == 0) ? 0 : 1;
                    end
                end
                2: m_len[ch] = int'(d[7:0]);
                default: ;
            endcase
        end

        m_k  = m_k + 1;
        e.ft = ((m_k % FD) == FD - 1);
        for (int c = 0; c < NCH; c++) begin
            e.period[16*c +: 16] = 16'(m_period[c]);
            e.volume[5*c +: 5]   = (m_act[c] != 0) ? 5'(m_vol[c]) : 5'd0;
            e.width[3*c +: 3]    = 3'(m_width[c]);
            e.active[c]          = (m_act[c] != 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic we, input logic re, input logic [3:0] a, input logic [15:0] d);
        wr_en = we; rd_en = re; addr = a; wdata = d;
        @(posedge clk);
        model_step(we, re, a, d);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic rand_cycle();
        logic        we, re;
        logic [3:0]  a;
        logic [15:0] d;
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 2) == 0);
        a  = 4'($urandom_range(0, 15));
        d  = 16'($urandom);
        if (a[1:0] == 2'd2) d = 16'($urandom_range(0, 5));
        cycle(we, re, a, d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, 64'(ch_period), 64'd0);
        check({tag, "_volume"}, 64'(ch_volume), 64'd0);
        check({tag, "_width"},  64'(ch_width),  64'd0);
        check({tag, "_active"}, 64'(ch_active), 64'd0);
        check({tag, "_tick"},   64'(frame_tick), 64'd0);
        check({tag, "_rdata"},  64'(rdata),     64'd0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("period",     64'(ch_period),  64'(e.period));
            check("volume",     64'(ch_volume),  64'(e.volume));
            check("width",      64'(ch_width),   64'(e.width));
            check("active",     64'(ch_active),  64'(e.active));
            check("frame_tick", 64'(frame_tick), 64'(e.ft));
            if (e.rd_chk) check("rdata", 64'(rdata), 64'(e.rdata));
        end
    end

    initial begin
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running ticks with no writes
        idle(24);
        // Ch1 PERIOD
        cycle(1'b1, 1'b0, {2'd1, 2'd0}, 16'h0123);
        // Ch0 LENGTH=3 then trigger with len_en, init_vol 20, width 2
        cycle(1'b1, 1'b0, {2'd0, 2'd2}, 16'd3);
        cycle(1'b1, 1'b0, {2'd0, 2'd1}, 16'h9000 | 16'd20 | (16'd2 << 5));
        // Ch2 decaying envelope from 2, period 1
        cycle(1'b1, 1'b0, {2'd2, 2'd1}, 16'h8000 | (16'd1 << 9) | 16'd2);
        // Ch3 rising envelope from 30, period 2
        cycle(1'b1, 1'b0, {2'd3, 2'd1}, 16'h8000 | (16'd2 << 9) | (16'd1 << 8) | 16'd30);
        idle(40);
        // Trigger on the tick cycle, then read STATUS
        while ((m_k % FD) != FD - 1) idle(1);
        cycle(1'b1, 1'b0, {2'd1, 2'd1}, 16'h8000 | (16'd5 << 9) | 16'd10);
        cycle(1'b0, 1'b1, {2'd1, 2'd3}, 16'd0);
        // Same-cycle read and write returns the old value
        cycle(1'b1, 1'b1, {2'd1, 2'd0}, 16'hBEEF);
        cycle(1'b0, 1'b1, {2'd1, 2'd1}, 16'd0);

        for (int i = 0; i < 1500; i++) rand_cycle();

        // Asynchronous reset mid-operation with a pending read value
        cycle(1'b1, 1'b0, {2'd0, 2'd0}, 16'h5A5A);
        cycle(1'b0, 1'b1, {2'd0, 2'd0}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) rand_cycle();

        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- CPU-facing register file and timing controller that configures and sequences NUM_CH square/noise sound channels.
- Holds per-channel period, width and volume settings, and drives each channel's period/volume/width inputs.
- Applies a frame-tick length counter (auto-silence) and a volume envelope (linear ramp) per channel.
- Sits between the CPU bus and the bank of sound channel instances.

Parameters:
- NUM_CH, 4: number of channels controlled.
- FRAME_DIV, 100000: clocks per frame tick (envelope/length timebase); must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  single-cycle write strobe; always accepted
- rd_en  in  1  single-cycle read strobe
- addr  in  2+log2(NUM_CH)  bits[1:0] register select, upper bits channel index
- wdata  in  16  write data
- rdata  out  16  read data, valid the cycle after rd_en
- ch_period  out  16*NUM_CH  per-channel period; channel i at [16i+15:16i]
- ch_volume  out  5*NUM_CH  per-channel effective volume (0 when inactive)
- ch_width  out  3*NUM_CH  per-channel width/noise select
- ch_active  out  NUM_CH  channel playing flags
- frame_tick  out  1  one-cycle pulse every FRAME_DIV clocks

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all registers, counters, rdata and outputs are 0; the tick divider is 0.
- Register map, per channel:
  - reg0 PERIOD: [15:0] period, applied to ch_period the next cycle.
  - reg1 CTRL, fields:
    - [4:0] init_vol
    - [7:5] width
    - [8] env_up
    - [11:9] env_per
    - [12] len_en
    - [15] trigger (write-only, self-clearing; reads 0).
  - reg2 LENGTH: [7:0] load value; a write loads len_cnt immediately.
  - reg3 STATUS (read-only; writes ignored): [4:0] cur_vol, [7:5] env_cnt, [8] active, [15:9] 0.
- CTRL write:
  - width, env_up, env_per and len_en are stored and take effect the next cycle.
  - init_vol is stored only; cur_vol is unchanged unless trigger=1.
- Trigger (CTRL write with bit 15 = 1):
  - cur_vol <= init_vol; env_cnt <= env_per.
  - active <= 1, except when len_en=1 and len_cnt=0, in which case active <= 0.
- Frame divider:
  - Counts 0..FRAME_DIV-1 and wraps.
  - frame_tick is asserted while the count equals FRAME_DIV-1.
  - The per-channel updates below occur on that same edge.
- Length, on tick:
  - Applies when active, len_en=1 and len_cnt != 0.
  - len_cnt <= len_cnt-1; if it becomes 0, active <= 0.
  - len_cnt is never decremented below 0.
- Envelope, on tick, when active and env_per != 0:
  - If env_cnt <= 1: step cur_vol by +1 (env_up) or -1, saturating at 31 / 0; then env_cnt <= env_per.
  - Otherwise: env_cnt <= env_cnt-1.
  - env_per = 0 freezes cur_vol.
- Envelope reaching volume 0 does not clear active.
- Outputs:
  - ch_volume = active ? cur_vol : 0.
  - All outputs are registered; a write is visible on the outputs exactly 1 cycle after wr_en.
- Simultaneous events:
  - Write and tick in the same cycle to the same channel: the written or triggered values win.
  - Tick-driven updates of other fields still apply.
  - A trigger on a tick cycle loads fresh counters; that tick is not applied on top of them.
- Read/write to the same address in the same cycle: rdata returns the pre-write value.
- Channel index >= NUM_CH: writes are ignored and reads return 0.
- Reset asserted mid-operation clears everything immediately, including a pending rdata.

Decomposition:
- Shared package (sound_pkg):
  - register offsets REG_PERIOD/REG_CTRL/REG_LENGTH/REG_STATUS;
  - CTRL bit positions;
  - VOL_MAX=31.
- One sub-module: sound_seq_chan, one instance per channel. It holds the per-channel registers, len_cnt, env_cnt and cur_vol. Inputs: decoded write strobes, wdata, tick.
- The top level holds the frame divider, address decode and read mux.

Test Plan (FRAME_DIV=8):
- Reset release, no writes -> all outputs 0; frame_tick pulses at cycles 7, 15, 23 after reset.
- Ch1 PERIOD=0x0123 -> ch_period[31:16]=0x0123 one cycle later; ch_volume[9:5] stays 0 (inactive).
- Ch0 LENGTH=3, then CTRL = len_en | trigger | init_vol 20 | width 2:
  - ch_active[0]=1, ch_volume[4:0]=20, ch_width[2:0]=2;
  - active drops to 0 on the 3rd tick, and volume reads 0 from then on.
- Ch2 trigger with init_vol 2, env_per 1, env_up=0 -> volume 1 after tick 1, then 0 after tick 2, and stays 0 with active still 1.
- Ch3 trigger with init_vol 30, env_per 2, env_up=1 -> volume 31 after tick 2, then saturates at 31.
- CTRL trigger written in the tick cycle -> len_cnt/env_cnt take the new loads with no same-cycle decrement; STATUS read the following cycle shows env_cnt=env_per.
